dt_skeleton: RTL
================

Name: dt_skeleton

Overview:
- Downstream consumer of the distance-transform stage.
- Starts when the DT stage raises its done flag, then scans the 128x128 8-bit distance map in the result RAM.
- Marks medial-axis (local-maximum) pixels and writes them as a packed 1024x16 binary skeleton image to a skeleton RAM.
- Also reports the maximum distance and the skeleton pixel count.

Parameters:
- LOG_W, 7, log2 of image width and height (128x128).
- DW, 8, distance value width (matches res_di).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level from the DT stage's done; sampled only in IDLE.
- res_rd  output  1  result-RAM read strobe.
- res_addr  output  14  result-RAM address, {y,x}.
- res_di  input  8  result-RAM read data; valid one cycle after res_rd/res_addr.
- skl_wr  output  1  skeleton-RAM write strobe, one cycle per word.
- skl_addr  output  10  skeleton word address, {y, x[6:4]}.
- skl_do  output  16  packed skeleton word; bit k = pixel x = 16*x[6:4]+k.
- max_dist  output  8  maximum distance over the whole image.
- skl_cnt  output  15  number of skeleton pixels (0..16384).
- done  output  1  high from scan completion until the next start.

Behaviour:
- Interface (already decided): one clock, clk; reset is asynchronous and active-low, named reset. All outputs are registered.
- Reset values: res_rd=0, res_addr=0, skl_wr=0, skl_addr=0, skl_do=0, max_dist=0, skl_cnt=0, done=0. FSM goes to IDLE; x=y=0; word shift register cleared.
- Reset mid-scan aborts immediately. No partial word is written after reset deasserts.
- States: IDLE, FETCH, EVAL, WRITE, FINISH.
- IDLE:
  - start=1 -> FETCH.
  - Clears x, y, max_dist, skl_cnt and done on the transition.
- FETCH (6 cycles, slot counter k=0..5):
  - At k=0..4, issue reads in order C {y,x}, N {y-1,x}, S {y+1,x}, W {y,x-1}, E {y,x+1}.
  - At k=1..5, capture res_di into the slot issued the previous cycle.
  - Out-of-range neighbours (y=0 for N, y=127 for S, x=0 for W, x=127 for E): res_rd=0 for that slot, value forced to 0. res_addr holds its previous value; it never wraps.
  - After k=5 -> EVAL.
- EVAL (1 cycle):
  - skel = (C!=0) && C>=N && C>=S && C>=W && C>=E, unsigned 8-bit compares. Plateaus count as skeleton.
  - Shift skel into word bit x[3:0].
  - skl_cnt += skel.
  - max_dist = max(max_dist, C).
  - If x[3:0]==15 -> WRITE; else x+=1 -> FETCH.
- WRITE (1 cycle):
  - skl_wr=1, skl_addr={y,x[6:4]}, skl_do=completed word.
  - Clear the word register.
  - If x==127 and y==127 -> FINISH. Else advance: x wraps 127->0 with y+=1, otherwise x+=1; -> FETCH.
- FINISH:
  - done=1 is registered on entry and held; max_dist and skl_cnt are stable.
  - Stays here while start=1. start=0 -> IDLE; done stays 1 until a new start is accepted.
- start while not in IDLE is ignored.
- Latency from start sampled high to done=1: 16384*7 + 1024 + 1 = 115713 cycles.
- skl_wr and res_rd are never high in the same cycle.

Decomposition:
- Shared package dt_pkg:
  - IMG_W=128, IMG_H=128, ADDR_W=14, WORD_W=16, STI_ADDR_W=10.
  - State encodings for dt_skeleton.
  - Pixel/word address packing function {y,x} and {y,x[6:4]}, shared with the DT stage.
- One sub-module, dt_lmax_cmp: combinational 5-input local-max compare returning skel. Instantiated once, in EVAL.

Test Plan:
- All-zero map, start=1 -> 1024 writes of skl_do=0x0000; max_dist=0; skl_cnt=0; done rises exactly 115713 cycles after start.
- Single pixel value 1 at (x=5,y=3), rest 0 -> word at skl_addr=24 equals 0x0020, all other words 0; skl_cnt=1; max_dist=1.
- 5x5 square DT (rings 1,2 and center 3) at x=10..14, y=20..24 -> skeleton is the 9 diagonal pixels; skl_cnt=9; max_dist=3; words at addr 160..192 step 8 have the correct bits.
- Value 5 at (127,127) with neighbours 0 -> no res_rd during the S and E slots; bit 15 of word 1023 set; skl_cnt=1.
- Reset asserted at pixel (64,40) mid-FETCH -> all outputs at reset values in the same cycle; a restart with start=1 produces a full correct scan and final counts.
- start held high after done -> no rescan; drop start then raise it -> done falls, counters clear, and the rescan gives identical results.

Source files
------------

// File: rtl/dt_pkg.sv
// Shared definitions for the distance-transform pipeline.
//
// Contents:
//   - Image geometry and RAM widths for the 128x128 map.
//   - State encoding for dt_skeleton.
//   - Address packing helpers used by both the DT stage and the skeleton
//     scanner. The image side length is passed in as log2, so the
//     scanner can also be built for smaller square images.
package dt_pkg;

    localparam int unsigned IMG_W      = 128;
    localparam int unsigned IMG_H      = 128;
    localparam int unsigned ADDR_W     = 14;
    localparam int unsigned WORD_W     = 16;
    localparam int unsigned STI_ADDR_W = 10;
    localparam int unsigned COORD_W    = ADDR_W / 2;
    localparam int unsigned WORD_LOG   = 4;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StEval,
        StWrite,
        StFinish
    } skl_state_t;

    // Pixel address {y,x} for an image of side 2**log_w.
    function automatic logic [ADDR_W-1:0] pix_addr(input int unsigned log_w,
                                                   input coord_t y,
                                                   input coord_t x);
        logic [ADDR_W-1:0] yy;
        logic [ADDR_W-1:0] xx;
        yy = ADDR_W'(y);
        xx = ADDR_W'(x);
        return (yy << log_w) | xx;
    endfunction

    // Packed-word address {y, x[log_w-1:4]} for an image of side 2**log_w.
    function automatic logic [STI_ADDR_W-1:0] word_addr(input int unsigned log_w,
                                                        input coord_t y,
                                                        input coord_t x);
        logic [ADDR_W-1:0] yy;
        logic [ADDR_W-1:0] xx;
        logic [ADDR_W-1:0] full;
        yy   = ADDR_W'(y);
        xx   = ADDR_W'(x);
        full = (yy << (log_w - WORD_LOG)) | (xx >> WORD_LOG);
        return full[STI_ADDR_W-1:0];
    endfunction

endpackage

// File: rtl/dt_lmax_cmp.sv
// Five-point local-maximum test for the skeleton scanner.
//
// Ports:
//   c          centre distance value
//   n, s, w, e neighbour distance values (0 when outside the image)
//   skel       1 when c is non-zero and not smaller than any neighbour
//
// Plateaus (equal neighbours) count as skeleton so that ridges of even
// width are not lost.
module dt_lmax_cmp #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] c,
    input  logic [DW-1:0] n,
    input  logic [DW-1:0] s,
    input  logic [DW-1:0] w,
    input  logic [DW-1:0] e,
    output logic          skel
);

    assign skel = (c != '0) && (c >= n) && (c >= s) && (c >= w) && (c >= e);

endmodule

// File: rtl/dt_skeleton.sv
// Medial-axis extraction from a distance map.
//
// After the DT stage signals done, scans the square distance map in the
// result RAM in raster order. Each pixel takes 6 FETCH cycles (reads of
// C, N, S, W, E) and one EVAL cycle; every 16th pixel is followed by a
// WRITE cycle storing the packed skeleton word.
//
// Ports:
//   clk       rising-edge clock
//   reset     asynchronous active-low reset
//   start     DT-stage done level; only looked at in IDLE
//   res_rd    result-RAM read strobe
//   res_addr  result-RAM address {y,x}
//   res_di    result-RAM read data, valid one cycle after res_rd
//   skl_wr    skeleton-RAM write strobe
//   skl_addr  skeleton word address {y, x[LOG_W-1:4]}
//   skl_do    packed skeleton word, bit k = pixel x[3:0]==k
//   max_dist  largest distance seen in the scan
//   skl_cnt   number of skeleton pixels
//   done      high from scan completion until the next accepted start
module dt_skeleton
    import dt_pkg::*;
#(
    parameter int unsigned LOG_W = 7,
    parameter int unsigned DW    = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    output logic                 res_rd,
    output logic [2*LOG_W-1:0]   res_addr,
    input  logic [DW-1:0]        res_di,
    output logic                 skl_wr,
    output logic [2*LOG_W-5:0]   skl_addr,
    output logic [WORD_W-1:0]    skl_do,
    output logic [DW-1:0]        max_dist,
    output logic [2*LOG_W:0]     skl_cnt,
    output logic                 done
);

    localparam int unsigned AW = 2 * LOG_W;
    localparam int unsigned SW = 2 * LOG_W - 4;
    localparam int unsigned CW = 2 * LOG_W + 1;
    localparam logic [LOG_W-1:0] XMax = '1;

    // Slot order inside FETCH
    localparam logic [2:0] SlotC = 3'd0;
    localparam logic [2:0] SlotN = 3'd1;
    localparam logic [2:0] SlotS = 3'd2;
    localparam logic [2:0] SlotW = 3'd3;
    localparam logic [2:0] SlotE = 3'd4;
    localparam logic [2:0] SlotLast = 3'd5;

    skl_state_t        state_q;
    logic [2:0]        k_q;
    logic [LOG_W-1:0]  x_q;
    logic [LOG_W-1:0]  y_q;
    logic [WORD_W-1:0] word_q;
    logic [DW-1:0]     val_c;
    logic [DW-1:0]     val_n;
    logic [DW-1:0]     val_s;
    logic [DW-1:0]     val_w;
    logic [DW-1:0]     val_e;

    logic              skel;
    logic [DW-1:0]     cap_val;
    logic              nxt_valid;
    logic [AW-1:0]     nxt_addr;
    logic [LOG_W-1:0]  nx;
    logic [LOG_W-1:0]  ny;
    logic [AW-1:0]     c0_next_addr;
    logic [WORD_W-1:0] skel_bit;
    logic [STI_ADDR_W-1:0] wa_full;

    // Neighbour slots that fall outside the image are never read.
    function automatic logic slot_valid(input logic [2:0] k,
                                        input logic [LOG_W-1:0] x,
                                        input logic [LOG_W-1:0] y);
        case (k)
            SlotN:   return y != '0;
            SlotS:   return y != XMax;
            SlotW:   return x != '0;
            SlotE:   return x != XMax;
            default: return 1'b1;
        endcase
    endfunction

    function automatic logic [AW-1:0] slot_addr(input logic [2:0] k,
                                                input logic [LOG_W-1:0] x,
                                                input logic [LOG_W-1:0] y);
        logic [LOG_W-1:0]  sx;
        logic [LOG_W-1:0]  sy;
        logic [ADDR_W-1:0] a;
        sx = x;
        sy = y;
        case (k)
            SlotN:   sy = y - LOG_W'(1);
            SlotS:   sy = y + LOG_W'(1);
            SlotW:   sx = x - LOG_W'(1);
            SlotE:   sx = x + LOG_W'(1);
            default: ;
        endcase
        a = pix_addr(LOG_W, coord_t'(sy), coord_t'(sx));
        return a[AW-1:0];
    endfunction

    dt_lmax_cmp #(
        .DW(DW)
    ) u_lmax (
        .c    (val_c),
        .n    (val_n),
        .s    (val_s),
        .w    (val_w),
        .e    (val_e),
        .skel (skel)
    );

    always_comb begin
        // Data arriving now belongs to the slot issued last cycle.
        cap_val      = slot_valid(k_q - 3'd1, x_q, y_q) ? res_di : '0;
        nxt_valid    = slot_valid(k_q + 3'd1, x_q, y_q);
        nxt_addr     = slot_addr(k_q + 3'd1, x_q, y_q);
        nx           = x_q + LOG_W'(1);
        ny           = (x_q == XMax) ? y_q + LOG_W'(1) : y_q;
        c0_next_addr = slot_addr(SlotC, nx, ny);
        skel_bit     = {{(WORD_W-1){1'b0}}, skel} << x_q[3:0];
        wa_full      = word_addr(LOG_W, coord_t'(y_q), coord_t'(x_q));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            k_q      <= '0;
            x_q      <= '0;
            y_q      <= '0;
            word_q   <= '0;
            val_c    <= '0;
            val_n    <= '0;
            val_s    <= '0;
            val_w    <= '0;
            val_e    <= '0;
            res_rd   <= 1'b0;
            res_addr <= '0;
            skl_wr   <= 1'b0;
            skl_addr <= '0;
            skl_do   <= '0;
            max_dist <= '0;
            skl_cnt  <= '0;
            done     <= 1'b0;
        end else begin
            skl_wr <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q  <= StFetch;
                        k_q      <= '0;
                        x_q      <= '0;
                        y_q      <= '0;
                        word_q   <= '0;
                        max_dist <= '0;
                        skl_cnt  <= '0;
                        done     <= 1'b0;
                        // Centre read of pixel (0,0) goes out in slot 0.
                        res_rd   <= 1'b1;
                        res_addr <= '0;
                    end
                end

                StFetch: begin
                    unique case (k_q)
                        SlotN:    val_c <= cap_val;
                        SlotS:    val_n <= cap_val;
                        SlotW:    val_s <= cap_val;
                        SlotE:    val_w <= cap_val;
                        SlotLast: val_e <= cap_val;
                        default:  ;
                    endcase
                    // Set up the read for the following slot; out-of-range
                    // slots leave res_addr where it was.
                    if (k_q < SlotE) begin
                        res_rd <= nxt_valid;
                        if (nxt_valid) begin
                            res_addr <= nxt_addr;
                        end
                    end else begin
                        res_rd <= 1'b0;
                    end
                    if (k_q == SlotLast) begin
                        state_q <= StEval;
                        k_q     <= '0;
                    end else begin
                        k_q <= k_q + 3'd1;
                    end
                end

                StEval: begin
                    skl_cnt <= skl_cnt + {{(CW-1){1'b0}}, skel};
                    if (val_c > max_dist) begin
                        max_dist <= val_c;
                    end
                    if (x_q[3:0] == 4'hf) begin
                        state_q  <= StWrite;
                        skl_wr   <= 1'b1;
                        skl_addr <= wa_full[SW-1:0];
                        skl_do   <= word_q | skel_bit;
                    end else begin
                        word_q   <= word_q | skel_bit;
                        x_q      <= nx;
                        state_q  <= StFetch;
                        res_rd   <= 1'b1;
                        res_addr <= c0_next_addr;
                    end
                end

                StWrite: begin
                    word_q <= '0;
                    if (x_q == XMax && y_q == XMax) begin
                        state_q <= StFinish;
                    end else begin
                        x_q      <= nx;
                        y_q      <= ny;
                        state_q  <= StFetch;
                        res_rd   <= 1'b1;
                        res_addr <= c0_next_addr;
                    end
                end

                StFinish: begin
                    done <= 1'b1;
                    if (!start) begin
                        state_q <= StIdle;
                    end
                end

                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
